// File: rtl/dm_responder.sv
// ----------------------------------------------------------------------------
// dm_responder
//   Data-memory responder for the MEM-stage interface. Decodes RV64 load and
//   store sizes, merges store byte lanes into a word array, sign/zero extends
//   load data and models a fixed access latency behind a busy/ready handshake.
//   Optional macro DM_PERF_CNT_EN adds rd_count, wr_count and err_count.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dm_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_din,
  input  logic [2:0]  dm_rd_ctrl,
  input  logic [2:0]  dm_wr_ctrl,
  output logic [63:0] dm_dout,
  output logic        dm_busy,
  output logic        dm_ready,
  output logic        dm_err
`ifdef DM_PERF_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [15:0] err_count
`endif
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) << 3;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, din_q, dout_q;
  logic [2:0]  rd_q, wr_q;
  logic        enter_resp;

  logic [63:0] mem_q [DEPTH];

  // Request present on the interface (only meaningful while idle)
  logic req;
  assign req = (dm_rd_ctrl != 3'd0) || (dm_wr_ctrl != 3'd0);

  // While idle the live inputs describe the access (needed when LATENCY=1
  // makes the accept edge also the edge entering RESP); otherwise the
  // captured copy does, so held or changed inputs are ignored.
  logic        idle;
  logic [63:0] acc_addr, acc_din;
  logic [2:0]  acc_rd, acc_wr;
  assign idle     = (state_q == S_IDLE);
  assign acc_addr = idle ? dm_addr    : addr_q;
  assign acc_din  = idle ? dm_din     : din_q;
  assign acc_rd   = idle ? dm_rd_ctrl : rd_q;
  assign acc_wr   = idle ? dm_wr_ctrl : wr_q;

  // Size decode, fault detection, load extension and store lane merge
  logic          is_rd, is_wr, fault;
  logic [1:0]    lg;
  logic [2:0]    off;
  logic [AW-1:0] widx;
  logic [7:0]    be;
  logic [63:0]   rd_word, shifted, wr_shifted, load_ext, merged;
  assign off     = acc_addr[2:0];
  assign widx    = acc_addr[AW+2:3];
  assign rd_word = mem_q[widx];

  always_comb begin
    is_rd = (acc_rd != 3'd0);
    is_wr = (acc_wr != 3'd0);
    lg    = 2'd0;
    if (is_rd) begin
      case (acc_rd)
        3'd3, 3'd4: lg = 2'd1;
        3'd5, 3'd6: lg = 2'd2;
        3'd7:       lg = 2'd3;
        default:    lg = 2'd0;
      endcase
    end else begin
      case (acc_wr)
        3'd2:    lg = 2'd1;
        3'd3:    lg = 2'd2;
        3'd4:    lg = 2'd3;
        default: lg = 2'd0;
      endcase
    end
    fault = ((lg == 2'd1) && off[0])
         || ((lg == 2'd2) && (off[1:0] != 2'd0))
         || ((lg == 2'd3) && (off != 3'd0))
         || (acc_addr >= MEM_BYTES)
         || (acc_wr > 3'd4)
         || (is_rd && is_wr);

    shifted = rd_word >> {off, 3'b000};
    case (acc_rd)
      3'd1:    load_ext = {{56{shifted[7]}}, shifted[7:0]};
      3'd2:    load_ext = {56'd0, shifted[7:0]};
      3'd3:    load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'd4:    load_ext = {48'd0, shifted[15:0]};
      3'd5:    load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'd6:    load_ext = {32'd0, shifted[31:0]};
      default: load_ext = shifted;
    endcase

    case (lg)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0F;
      default: be = 8'hFF;
    endcase
    be         = be << off;
    wr_shifted = acc_din << {off, 3'b000};
    merged     = rd_word;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) merged[b*8 +: 8] = wr_shifted[b*8 +: 8];
    end
  end

  // Next-state logic of the access sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and request capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 64'd0;
      din_q   <= 64'd0;
      rd_q    <= 3'd0;
      wr_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req) begin
        addr_q <= dm_addr;
        din_q  <= dm_din;
        rd_q   <= dm_rd_ctrl;
        wr_q   <= dm_wr_ctrl;
      end
    end
  end

  // Store commit on the edge entering RESP; reset gating drops a pending store
  always_ff @(posedge clk) begin
    if (enter_resp && reset && is_wr && !fault) mem_q[widx] <= merged;
  end

  // Load result register; holds across stores, cleared by any fault
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= 64'd0;
    end else if (enter_resp) begin
      if (fault)      dout_q <= 64'd0;
      else if (is_rd) dout_q <= load_ext;
    end
  end

  assign dm_dout  = dout_q;
  assign dm_busy  = (state_q != S_IDLE);
  assign dm_ready = (state_q == S_RESP);
  assign dm_err   = dm_ready && fault;

`ifdef DM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  logic [15:0] err_cnt_q;

  // Completion counters, updated on the RESP cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q  <= 32'd0;
      wr_cnt_q  <= 32'd0;
      err_cnt_q <= 16'd0;
    end else if (state_q == S_RESP) begin
      if (fault) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (is_rd) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end else if (is_wr) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ----------------------------------------------------------------------------
// tb_dm_responder
//   Directed self-checking bench for dm_responder with a scoreboard queue of
//   expected responses.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dm_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] dm_addr, dm_din;
  logic [2:0]  dm_rd_ctrl, dm_wr_ctrl;
  logic [63:0] dm_dout;
  logic        dm_busy, dm_ready, dm_err;
`ifdef DM_PERF_CNT_EN
  logic [31:0] rd_count, wr_count;
  logic [15:0] err_count;
`endif

  dm_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .dm_addr    (dm_addr),
    .dm_din     (dm_din),
    .dm_rd_ctrl (dm_rd_ctrl),
    .dm_wr_ctrl (dm_wr_ctrl),
    .dm_dout    (dm_dout),
    .dm_busy    (dm_busy),
    .dm_ready   (dm_ready),
    .dm_err     (dm_err)
`ifdef DM_PERF_CNT_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] dout;
    logic        chk_dout;
    logic        is_rd;
    logic        is_wr;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   exp_rd = 0, exp_wr = 0, exp_errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for dm_ready, then pop and compare the oldest expectation
  task automatic wait_resp(input string tag, input int exp_lat, input bit clear);
    int   c;
    bit   got;
    exp_t e;
    c   = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (dm_ready === 1'b1) got = 1'b1;
    end
    ntests++;
    assert (got) else begin
      nfail++;
      $error("FAIL %s_timeout: observed no dm_ready expected dm_ready within 40 cycles", tag);
    end
    if (got) begin
      chk({tag, "_latency"}, 64'(c), 64'(exp_lat));
      ntests++;
      assert (sb.size() > 0) else begin
        nfail++;
        $error("FAIL %s_sb: observed response expected none queued", tag);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_err"}, 64'(dm_err), 64'(e.err));
        if (e.chk_dout) chk({tag, "_dout"}, dm_dout, e.dout);
        if (e.err)        exp_errs++;
        else if (e.is_rd) exp_rd++;
        else if (e.is_wr) exp_wr++;
      end
    end
    if (clear) begin
      dm_rd_ctrl = 3'd0;
      dm_wr_ctrl = 3'd0;
    end
  endtask

  task automatic push_exp(input logic [2:0] rd, input logic [2:0] wr, input logic err,
                          input logic [63:0] dout, input logic chk_d);
    exp_t e;
    e.err      = err;
    e.dout     = dout;
    e.chk_dout = chk_d;
    e.is_rd    = (rd != 3'd0);
    e.is_wr    = (wr != 3'd0);
    sb.push_back(e);
  endtask

  task automatic access(input string tag, input logic [2:0] rd, input logic [2:0] wr,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic exp_err, input logic [63:0] exp_dout, input logic chk_d);
    push_exp(rd, wr, exp_err, exp_dout, chk_d);
    @(negedge clk);
    dm_rd_ctrl = rd;
    dm_wr_ctrl = wr;
    dm_addr    = a;
    dm_din     = d;
    @(posedge clk);
    wait_resp(tag, LATENCY, 1'b1);
  endtask

  task automatic ld(input string tag, input logic [2:0] rd, input logic [63:0] a,
                    input logic [63:0] exp);
    access(tag, rd, 3'd0, a, 64'd0, 1'b0, exp, 1'b1);
  endtask

  task automatic st(input string tag, input logic [2:0] wr, input logic [63:0] a,
                    input logic [63:0] d);
    access(tag, 3'd0, wr, a, d, 1'b0, 64'd0, 1'b0);
  endtask

  localparam logic [63:0] VAL_A = 64'h1111_2222_3333_4444;
  localparam logic [63:0] VAL_B = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] VAL_C = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] VAL_W = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] TOP   = 64'(DEPTH) * 64'd8;

  initial begin
    reset      = 1'b0;
    dm_addr    = 64'd0;
    dm_din     = 64'd0;
    dm_rd_ctrl = 3'd0;
    dm_wr_ctrl = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(dm_busy),  64'd0);
    chk("rst_ready", 64'(dm_ready), 64'd0);
    chk("rst_err",   64'(dm_err),   64'd0);
    chk("rst_dout",  dm_dout,       64'd0);
    reset = 1'b1;

    // Reset asserted in WAIT with a store pending: store must be dropped
    st("sd_a", 3'd4, 64'h10, VAL_A);
    ld("ld_a", 3'd7, 64'h10, VAL_A);
    @(negedge clk);
    dm_wr_ctrl = 3'd4;
    dm_addr    = 64'h10;
    dm_din     = VAL_B;
    @(posedge clk);
    #1;
    chk("mid_busy", 64'(dm_busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy",  64'(dm_busy),  64'd0);
    chk("mid_rst_ready", 64'(dm_ready), 64'd0);
    chk("mid_rst_err",   64'(dm_err),   64'd0);
    chk("mid_rst_dout",  dm_dout,       64'd0);
    @(negedge clk);
    dm_wr_ctrl = 3'd0;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy2", 64'(dm_busy), 64'd0);
    exp_rd = 0; exp_wr = 0; exp_errs = 0;
    reset = 1'b1;
    ld("ld_after_rst", 3'd7, 64'h10, VAL_A);

    // Sizes and extension from one word
    access("sd_w", 3'd0, 3'd4, 64'h10, VAL_W, 1'b0, VAL_A, 1'b1);
    ld("ld",    3'd7, 64'h10, VAL_W);
    ld("lb",    3'd1, 64'h10, 64'hFFFF_FFFF_FFFF_FFEF);
    ld("lbu",   3'd2, 64'h10, 64'h0000_0000_0000_00EF);
    ld("lh16",  3'd3, 64'h16, 64'h0000_0000_0000_0123);
    ld("lw",    3'd5, 64'h10, 64'hFFFF_FFFF_89AB_CDEF);
    ld("lwu",   3'd6, 64'h10, 64'h0000_0000_89AB_CDEF);
    access("sb", 3'd0, 3'd1, 64'h11, 64'h55AA, 1'b0, 64'h0000_0000_89AB_CDEF, 1'b1);
    ld("ld_sb", 3'd7, 64'h10, 64'h0123_4567_89AB_AAEF);
    ld("lh12",  3'd3, 64'h12, 64'hFFFF_FFFF_FFFF_89AB);
    ld("lhu12", 3'd4, 64'h12, 64'h0000_0000_0000_89AB);

    // Faults
    access("lw_mis",  3'd5, 3'd0, 64'h12, 64'd0, 1'b1, 64'd0, 1'b1);
    ld("lh_clr", 3'd3, 64'h12, 64'hFFFF_FFFF_FFFF_89AB);
    access("sh_mis",  3'd0, 3'd2, 64'h13, 64'hFFFF, 1'b1, 64'd0, 1'b1);
    ld("ld_sh_mis", 3'd7, 64'h10, 64'h0123_4567_89AB_AAEF);
    access("rdwr",    3'd7, 3'd4, 64'h10, 64'd0, 1'b1, 64'd0, 1'b1);
    ld("ld_rdwr", 3'd7, 64'h10, 64'h0123_4567_89AB_AAEF);
    access("ld_oob",  3'd7, 3'd0, TOP, 64'd0, 1'b1, 64'd0, 1'b1);
    access("wr_ill",  3'd0, 3'd5, 64'h10, 64'd0, 1'b1, 64'd0, 1'b1);
    ld("ld_ill", 3'd7, 64'h10, 64'h0123_4567_89AB_AAEF);
    st("sd_top", 3'd4, TOP - 64'd8, VAL_B);
    ld("ld_top", 3'd7, TOP - 64'd8, VAL_B);

    // Controls changed during WAIT are ignored
    st("sd_c", 3'd4, 64'h20, VAL_C);
    push_exp(3'd7, 3'd0, 1'b0, VAL_C, 1'b1);
    @(negedge clk);
    dm_rd_ctrl = 3'd7;
    dm_addr    = 64'h20;
    @(posedge clk);
    #1;
    dm_rd_ctrl = 3'd0;
    dm_wr_ctrl = 3'd4;
    dm_din     = 64'd0;
    wait_resp("hold", LATENCY, 1'b1);
    ld("ld_hold", 3'd7, 64'h20, VAL_C);

    // Held request completes every LATENCY+1 cycles
    for (int k = 0; k < 3; k++) push_exp(3'd7, 3'd0, 1'b0, VAL_W - VAL_W + 64'h0123_4567_89AB_AAEF, 1'b1);
    @(negedge clk);
    dm_rd_ctrl = 3'd7;
    dm_addr    = 64'h10;
    @(posedge clk);
    wait_resp("b2b0", LATENCY, 1'b0);
    wait_resp("b2b1", LATENCY + 1, 1'b0);
    wait_resp("b2b2", LATENCY + 1, 1'b1);

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
`ifdef DM_PERF_CNT_EN
    chk("rd_count",  64'(rd_count),  64'(exp_rd));
    chk("wr_count",  64'(wr_count),  64'(exp_wr));
    chk("err_count", 64'(err_count), 64'(exp_errs));
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
